// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: multiply/divide timer
// state encoding, counter width and default operation latencies.
package pipe_ctrl_pkg;

    localparam int unsigned CntWidth          = 4;
    localparam int unsigned MultCyclesDefault = 5;
    localparam int unsigned DivCyclesDefault  = 10;

    typedef logic [CntWidth-1:0] md_cnt_t;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Multiply/divide occupancy timer: down-counts the operation latency and
// reports a registered busy flag plus a one-cycle completion pulse.
module pipe_ctrl_md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDefault,
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam md_cnt_t MultLoad = md_cnt_t'(MULT_CYCLES);
    localparam md_cnt_t DivLoad  = md_cnt_t'(DIV_CYCLES);

    md_state_e state_q;
    md_cnt_t   cnt_q;
    logic      done_q;

    // The unit keeps counting through freeze; only a new start reloads it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                cnt_q   <= is_div ? DivLoad : MultLoad;
                state_q <= StBusy;
            end else begin
                case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                    end
                    StBusy: begin
                        cnt_q <= cnt_q - md_cnt_t'(1);
                        if (cnt_q == md_cnt_t'(1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Loads are never zero, so StBusy is exactly cnt != 0.
    assign busy = (state_q == StBusy);
    assign done = done_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: write enables, bubble insertion and a
// saturating stall counter, with multiply/divide occupancy tracking.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDefault,
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard_stall,
    input  logic        freeze,
    input  logic        D_md_use,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        PC_WE,
    output logic        D_WE,
    output logic        E_WE,
    output logic        M_WE,
    output logic        W_WE,
    output logic        E_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    logic        start_acc;
    logic        md_stall;
    logic        stall;
    logic [31:0] stall_cnt_q;

    assign start_acc = E_start & ~freeze;

    pipe_ctrl_md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (start_acc),
        .is_div (E_is_div),
        .busy   (md_busy),
        .done   (md_done)
    );

    // An md op entering E also blocks a dependent D instruction this cycle.
    assign md_stall = D_md_use & (md_busy | E_start);
    assign stall    = (hazard_stall | md_stall) & ~freeze;

    always_comb begin
        PC_WE = 1'b0;
        D_WE  = 1'b0;
        E_WE  = 1'b0;
        M_WE  = 1'b0;
        W_WE  = 1'b0;
        E_clr = 1'b0;
        if (reset && !freeze) begin
            E_WE = 1'b1;
            M_WE = 1'b1;
            W_WE = 1'b1;
            if (stall) begin
                E_clr = 1'b1;
            end else begin
                PC_WE = 1'b1;
                D_WE  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized
// phase, all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        hazard_stall;
    logic        freeze;
    logic        D_md_use;
    logic        E_start;
    logic        E_is_div;
    logic        PC_WE;
    logic        D_WE;
    logic        E_WE;
    logic        M_WE;
    logic        W_WE;
    logic        E_clr;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cnt;

    int          n_vec;
    int          n_err;

    // Behavioural model state
    int          m_rem;
    logic        m_done;
    logic [31:0] m_cnt;

    pipe_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hazard_stall (hazard_stall),
        .freeze       (freeze),
        .D_md_use     (D_md_use),
        .E_start      (E_start),
        .E_is_div     (E_is_div),
        .PC_WE        (PC_WE),
        .D_WE         (D_WE),
        .E_WE         (E_WE),
        .M_WE         (M_WE),
        .W_WE         (W_WE),
        .E_clr        (E_clr),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall();
        logic busy;
        busy = (m_rem != 0);
        return (hazard_stall | (D_md_use & (busy | E_start))) & ~freeze;
    endfunction

    // Compare every output against the model for the inputs currently applied.
    task automatic check_all(input string tag);
        logic [5:0] exp_en;
        if (!reset)          exp_en = 6'b000000;
        else if (freeze)     exp_en = 6'b000000;
        else if (model_stall()) exp_en = 6'b001111;
        else                 exp_en = 6'b111110;
        check({tag, ".en"}, 32'({PC_WE, D_WE, E_WE, M_WE, W_WE, E_clr}), 32'(exp_en));
        check({tag, ".busy"}, 32'(md_busy), 32'(m_rem != 0));
        check({tag, ".done"}, 32'(md_done), 32'(m_done));
        check({tag, ".scnt"}, stall_cnt, m_cnt);
    endtask

    // Apply inputs, check, then advance one clock and update the model.
    task automatic step(input string tag, input logic hz, input logic frz, input logic du,
                        input logic st, input logic dv);
        logic s;
        logic acc;
        hazard_stall = hz;
        freeze       = frz;
        D_md_use     = du;
        E_start      = st;
        E_is_div     = dv;
        #1;
        check_all(tag);
        s   = model_stall();
        acc = st & ~frz;
        @(posedge clk);
        #2;
        if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_done = (m_rem == 1) && !acc;
        if (acc)            m_rem = dv ? DC : MC;
        else if (m_rem > 0) m_rem = m_rem - 1;
    endtask

    initial begin
        logic [31:0] c0;
        int          busy_cycles;
        n_vec = 0;
        n_err = 0;
        m_rem = 0;
        m_done = 1'b0;
        m_cnt = '0;
        reset = 1'b0;
        hazard_stall = 1'b0;
        freeze = 1'b0;
        D_md_use = 1'b0;
        E_start = 1'b0;
        E_is_div = 1'b0;

        // Reset state
        #2;
        check_all("reset");
        #10 reset = 1'b1;
        @(posedge clk);
        #2;

        // Mult start, no dependent use: busy 5 cycles, done in cycle 6
        step("mult_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check("mult.busy", 32'(md_busy), 32'(i < 5));
            check("mult.done", 32'(md_done), 32'(i == 5));
            step("mult_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("mult.nostall", stall_cnt, 32'd0);

        // Div start with mflo waiting in D: 11 stall cycles
        c0 = m_cnt;
        step("div_start", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i < 10) check("div.clr", 32'({PC_WE, D_WE, E_clr}), 32'b001);
            step("div_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("div.scnt", stall_cnt, c0 + 32'd11);
        step("div_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hazard and freeze together: freeze wins
        c0 = m_cnt;
        hazard_stall = 1'b1;
        freeze = 1'b1;
        #1;
        check("hzfrz.en", 32'({PC_WE, D_WE, E_WE, M_WE, W_WE, E_clr}), 32'd0);
        step("hzfrz", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hzfrz.scnt", stall_cnt, c0);

        // Mult with 3 frozen cycles: unit keeps counting
        step("mfrz_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (md_busy === 1'b1) busy_cycles++;
            step("mfrz_run", 1'b0, (i >= 1 && i <= 3), 1'b0, 1'b0, 1'b0);
        end
        check("mfrz.busy_cycles", 32'(busy_cycles), 32'd5);

        // Async reset at cnt=3 aborts the op
        step("rst_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        m_rem = 0;
        m_done = 1'b0;
        m_cnt = '0;
        #1;
        check_all("rst_async");
        @(posedge clk);
        #2;
        check_all("rst_hold");
        #3 reset = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            check("rst.nodone", 32'(md_done), 32'd0);
            step("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step("rst_restart", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst.restart_busy", 32'(md_busy), 32'd1);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), 1'($urandom));
        end

        // Saturation of the stall counter
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step("sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat.value", stall_cnt, 32'hFFFF_FFFF);
        step("sat_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat.hold", stall_cnt, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
